// File: rtl/hs4_rx_fifo.sv
// hs4_rx_fifo: receive end of a 4-phase req/ack link, buffering words into a FIFO.
// Latency: data_req sampled high at edge k -> push and data_ack at edge k+SYNC_STAGES.
// Backpressure: data_ack is withheld while the FIFO is full; downstream uses valid/ready.

// hs4_fifo: generic register-file FIFO with a registered occupancy count.
// Latency: one edge from push to out valid; read data is combinational from storage.
// Backpressure: push_rdy drops when full; pops while empty are ignored.
module hs4_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [DW-1:0]            push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [DW-1:0]            pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count != FULL_CNT);
  assign pop_vld  = (count != '0);
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Storage is not reset; its contents are only observable while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module hs4_rx_fifo #(
  parameter int DW          = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clkb,
  input  logic                     rst,
  input  logic                     data_req,
  input  logic [DW-1:0]            data,
  output logic                     data_ack,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               xfer_cnt
);
  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   cap_vld;
  logic                   cap_rdy;

  // data itself is never synchronized: it is only sampled once req_s is high.
  always_ff @(posedge clkb) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkb) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One capture per handshake: only IDLE may push, and only when there is room.
  always_comb begin
    state_d = state_q;
    cap_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && cap_rdy) begin
          cap_vld = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_ack = (state_q == ST_ACK);

  always_ff @(posedge clkb) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (cap_vld) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

  hs4_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clkb),
    .rst      (rst),
    .push_vld (cap_vld),
    .push_rdy (cap_rdy),
    .push_dat (data),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Bench for hs4_rx_fifo: directed vector table, handshake sequences and a random
// sender/consumer mix checked against a queue-based model of the receiver.
module tb_hs4_rx_fifo;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clkb = 1'b0;
  logic          rst = 1'b1;
  logic          data_req = 1'b0;
  logic [DW-1:0] data = '0;
  logic          out_ready = 1'b0;
  logic          data_ack;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [CW-1:0] fifo_count;
  logic [7:0]    xfer_cnt;

  hs4_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clkb       (clkb),
    .rst        (rst),
    .data_req   (data_req),
    .data       (data),
    .data_ack   (data_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clkb = ~clkb;

  int total = 0;
  int bad = 0;
  bit use_model = 1'b0;
  bit rand_rdy = 1'b0;
  bit toggle_rdy = 1'b0;
  logic [DW-1:0] popped[$];

  // Receiver model: request history, ack flag, stored words, handshake count.
  bit            m_sync[SYNC];
  bit            m_ack;
  logic [DW-1:0] mq[$];
  int            m_xfer;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit req_s;
    bit pop;
    bit push;
    int cnt;
    logic [DW-1:0] tmp;
    if (rst) begin
      foreach (m_sync[i]) m_sync[i] = 1'b0;
      m_ack = 1'b0;
      mq.delete();
      m_xfer = 0;
    end else begin
      req_s = m_sync[SYNC-1];
      cnt   = mq.size();
      pop   = (cnt != 0) && out_ready;
      push  = !m_ack && req_s && (cnt < DEPTH);
      if (pop) tmp = mq.pop_front();
      if (push) begin
        mq.push_back(data);
        m_xfer = (m_xfer + 1) % 256;
      end
      m_ack = m_ack ? req_s : push;
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = data_req;
    end
  endtask

  task automatic cyc();
    if (!rst && out_valid && out_ready) popped.push_back(out_data);
    @(posedge clkb);
    model_step();
    #1;
    if (use_model) begin
      check("m_ack", data_ack, m_ack);
      check("m_cnt", fifo_count, mq.size());
      check("m_vld", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("m_dat", out_data, mq[0]);
      check("m_xfer", xfer_cnt, m_xfer);
    end
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else if (toggle_rdy) out_ready = !out_ready;
  endtask

  task automatic send(input logic [DW-1:0] d, input int hold);
    bit ok;
    data = d;
    data_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cyc();
      ok = data_ack;
    end
    check("ack_rise", ok, 1);
    repeat (hold) cyc();
    data_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      ok = !data_ack;
    end
    check("ack_fall", ok, 1);
  endtask

  typedef struct {
    bit          rst;
    bit          req;
    logic [DW-1:0] dat;
    bit          rdy;
    bit          e_ack;
    int          e_cnt;
    bit          e_vld;
    logic [DW-1:0] e_dat;
    int          e_xfer;
  } vec_t;

  vec_t vec[10];

  initial begin
    int base;
    logic [DW-1:0] exp_w[$];

    // Single transfer, edge by edge, including empty-pop with no effect.
    vec[0] = '{1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0};
    vec[1] = '{1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0};
    vec[2] = '{0, 1, 4'hA, 0, 0, 0, 0, 4'h0, 0};
    vec[3] = '{0, 1, 4'hA, 0, 0, 0, 0, 4'h0, 0};
    vec[4] = '{0, 1, 4'hA, 0, 1, 1, 1, 4'hA, 1};
    vec[5] = '{0, 0, 4'hA, 0, 1, 1, 1, 4'hA, 1};
    vec[6] = '{0, 0, 4'hA, 0, 1, 1, 1, 4'hA, 1};
    vec[7] = '{0, 0, 4'hA, 0, 0, 1, 1, 4'hA, 1};
    vec[8] = '{0, 0, 4'hA, 1, 0, 0, 0, 4'h0, 1};
    vec[9] = '{0, 0, 4'hA, 1, 0, 0, 0, 4'h0, 1};

    for (int i = 0; i < 10; i++) begin
      rst = vec[i].rst;
      data_req = vec[i].req;
      data = vec[i].dat;
      out_ready = vec[i].rdy;
      cyc();
      check($sformatf("v%0d_ack", i), data_ack, vec[i].e_ack);
      check($sformatf("v%0d_cnt", i), fifo_count, vec[i].e_cnt);
      check($sformatf("v%0d_vld", i), out_valid, vec[i].e_vld);
      if (vec[i].e_vld) check($sformatf("v%0d_dat", i), out_data, vec[i].e_dat);
      check($sformatf("v%0d_xfer", i), xfer_cnt, vec[i].e_xfer);
    end

    use_model = 1'b1;

    // Back-to-back stream, consumer always ready.
    popped.delete();
    base = m_xfer;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'(i), 0);
    repeat (4) cyc();
    check("stream_n", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++) check("stream_dat", popped[i], i);
    check("stream_xfer", xfer_cnt, (base + 8) % 256);
    check("stream_cnt", fifo_count, 0);

    // Backpressure: four words fill the FIFO, the fifth waits for a pop.
    popped.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'(i), 0);
    data = 4'h5;
    data_req = 1'b1;
    repeat (8) cyc();
    check("bp_ack_held", data_ack, 0);
    check("bp_full", fifo_count, 4);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp_pop_ack", data_ack, 0);
    check("bp_pop_cnt", fifo_count, 3);
    cyc();
    check("bp_late_ack", data_ack, 1);
    check("bp_late_cnt", fifo_count, 4);
    data_req = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1;
    repeat (6) cyc();
    check("bp_n", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) check("bp_dat", popped[i], i + 1);

    // Wrap-around with the consumer toggling every cycle.
    popped.delete();
    exp_w.delete();
    toggle_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_w.push_back(4'((i * 7 + 3) % 16));
      send(4'((i * 7 + 3) % 16), 0);
    end
    toggle_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();
    check("wrap_n", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) check("wrap_dat", popped[i], exp_w[i]);

    // Long request: one push, ack high throughout.
    out_ready = 1'b0;
    base = m_xfer;
    data = 4'h7;
    data_req = 1'b1;
    for (int i = 0; i < 4 && !data_ack; i++) cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("long_ack", data_ack, 1);
    end
    data_req = 1'b0;
    repeat (3) cyc();
    check("long_ack_low", data_ack, 0);
    check("long_cnt", fifo_count, 1);
    check("long_xfer", xfer_cnt, (base + 1) % 256);

    // Reset mid-handshake with three words stored and req still high.
    send(4'h8, 0);
    data = 4'h9;
    data_req = 1'b1;
    for (int i = 0; i < 10 && !data_ack; i++) cyc();
    check("rst_pre_ack", data_ack, 1);
    check("rst_pre_cnt", fifo_count, 3);
    rst = 1'b1;
    cyc();
    check("rst_ack", data_ack, 0);
    check("rst_cnt", fifo_count, 0);
    check("rst_vld", out_valid, 0);
    check("rst_xfer", xfer_cnt, 0);
    rst = 1'b0;
    cyc();
    check("rel1_ack", data_ack, 0);
    cyc();
    check("rel2_ack", data_ack, 0);
    cyc();
    check("rel3_ack", data_ack, 1);
    check("rel3_dat", out_data, 9);
    data_req = 1'b0;
    repeat (3) cyc();

    // Random sender timing and consumer readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) cyc();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("rand_drain", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hs4_rx_fifo.md
Name: hs4_rx_fifo

Overview:
- Responder (clkb-side) end of the 4-phase req/ack transfer protocol used between data_sender and data_receiver.
- Synchronizes the asynchronous data_req into its own clock domain and captures data while req is high.
- Pushes each captured word into a small FIFO and drives data_ack with full 4-phase return-to-zero sequencing.
- Presents buffered words downstream on a valid/ready stream and applies backpressure by withholding data_ack while the FIFO is full.

Parameters:
- DW, 4, data width of data and out_data.
- DEPTH, 4, FIFO depth in words; must be a power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on data_req; minimum 2.

Ports:
- clkb  input  1  receive-domain clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_req  input  1  request from the sender; asynchronous to clkb.
- data  input  DW  sender data; stable from before data_req rises until data_ack is seen high by the sender.
- data_ack  output  1  acknowledge to the sender; registered.
- out_data  output  DW  head-of-FIFO word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data when out_valid&&out_ready.
- fifo_count  output  $clog2(DEPTH)+1  words currently stored.
- xfer_cnt  output  8  completed handshakes (push count); wraps 255->0.

Behaviour:
- Reset (rst=1 at a clkb edge) sets:
  - data_ack=0, FSM=IDLE, all sync flops=0.
  - wr_ptr=rd_ptr=0, fifo_count=0, out_valid=0, xfer_cnt=0.
  - out_data is don't-care while out_valid=0.
- Synchronizer:
  - req_s is the output of a SYNC_STAGES flop chain on data_req.
  - data is never synchronized; it is sampled only when req_s=1, which the protocol guarantees is stable.
- FSM is registered, with states IDLE and ACK:
  - IDLE: data_ack=0. If req_s=1 and fifo_count<DEPTH, then at that edge: write data to mem[wr_ptr], wr_ptr+1, set data_ack=1, increment xfer_cnt, go to ACK.
  - IDLE: if req_s=1 and the FIFO is full, stay in IDLE with data_ack=0 (backpressure; the sender holds req and data).
  - ACK: data_ack=1. When req_s=0, clear data_ack at that edge and go to IDLE. No capture is allowed in ACK.
- Latency with SYNC_STAGES=2, data_req first sampled high at edge k:
  - req_s goes high after edge k+1.
  - data_ack and the push happen at edge k+2.
  - On the falling side, data_ack clears at edge k'+2 after req is first sampled low at k'.
- Full/empty and pointers:
  - The full check uses the registered fifo_count.
  - A pop in the same cycle as a full-blocked IDLE does not enable the push; the push happens the following edge.
  - Pop occurs when out_valid&&out_ready: rd_ptr+1.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- out_data=mem[rd_ptr] (combinational read of registered storage). out_valid=(fifo_count!=0).
- out_ready while empty has no effect; fifo_count never underflows or exceeds DEPTH.
- Exactly one push per 4-phase handshake: a req held high for any length yields one word.
- Reset mid-handshake:
  - data_ack drops at the reset edge and FIFO contents are discarded.
  - If data_req is still high after reset release, it is treated as a new request and captured again after the synchronizer latency. The sender tolerates this because it re-sees ack rise.

Test Plan:
- Single transfer: rst released, sender drives data=4'hA and req=1 at edge k -> data_ack=1 at edge k+2, fifo_count=1, out_valid=1, out_data=4'hA, xfer_cnt=1. req=0 -> data_ack=0 two edges later.
- Back-to-back stream with out_ready=1: 8 handshakes with data 0..7 -> out_data sequence 0..7 in order, no duplicates or drops, xfer_cnt=8, fifo_count returns to 0.
- Backpressure: out_ready=0, 5 requests with DEPTH=4 -> 4 acks issued; the 5th req is held with data_ack=0 and fifo_count=4. Then one pop -> the 5th word is acked within 2 edges and fifo_count=4.
- Wrap-around: 10 words, alternating push and pop with out_ready toggling -> pointers wrap; output order matches input 10/10.
- Long req: req held high for 20 clkb cycles -> exactly one push, data_ack held high the entire time, xfer_cnt+1.
- Reset mid-operation: rst=1 while data_ack=1 and fifo_count=3 -> next edge data_ack=0, fifo_count=0, out_valid=0. req still high after release -> recaptured, data_ack=1 two edges after rst deasserts.
